// File: rtl/minc_trace_if.sv
// Trace capture bus: CPU sample inputs, arm/trigger control, readout handshake and status.
// Latency: n/a (signal bundle only).
// Backpressure: readout uses rd_valid/rd_ready; the sample inputs are not flow-controlled.
//
// Ports (master = driver/consumer side, slave = minc_trace):
//   pc_in, acc_in       CPU samples taken every cycle
//   arm, abort          start capture / return to idle
//   trig_en, trig_pc    PC-match trigger, or immediate trigger when trig_en = 0
//   post_count          number of samples to capture (0 or > DEPTH means DEPTH)
//   rd_ready            consumer accepts rd_data
//   rd_valid, rd_data, rd_index, cap_count, state_out, done  readout and status
interface minc_trace_if #(
   parameter int PC_W  = 8,
   parameter int ACC_W = 8,
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic [PC_W-1:0]       pc_in;
   logic [ACC_W-1:0]      acc_in;
   logic                  arm;
   logic                  abort;
   logic                  trig_en;
   logic [PC_W-1:0]       trig_pc;
   logic [AW:0]           post_count;
   logic                  rd_ready;
   logic                  rd_valid;
   logic [PC_W+ACC_W-1:0] rd_data;
   logic [AW:0]           rd_index;
   logic [AW:0]           cap_count;
   logic [1:0]            state_out;
   logic                  done;

   modport master (
      output pc_in, acc_in, arm, abort, trig_en, trig_pc, post_count, rd_ready,
      input  rd_valid, rd_data, rd_index, cap_count, state_out, done
   );

   modport slave (
      input  pc_in, acc_in, arm, abort, trig_en, trig_pc, post_count, rd_ready,
      output rd_valid, rd_data, rd_index, cap_count, state_out, done
   );
endinterface

// File: rtl/minc_trace.sv
// Trace buffer: after arm, waits for a trigger, captures N consecutive {pc, acc} samples, then plays them out.
// Latency: the trigger-cycle sample is stored at that edge; rd_data is combinational from storage at rd_index.
// Backpressure: readout holds rd_data/rd_index while rd_valid & !rd_ready; capture itself never stalls.
//
// Ports: CLK (rising edge), RESET (synchronous, active-high), bus (minc_trace_if.slave, see interface header).
module minc_trace #(
   parameter int PC_W  = 8,
   parameter int ACC_W = 8,
   parameter int DEPTH = 64
) (
   input  logic          CLK,
   input  logic          RESET,
   minc_trace_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = PC_W + ACC_W;
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] lim_q, lim_d;       // number of samples to capture
   logic [AW:0] cap_q, cap_d;       // samples captured; also the write pointer
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   arm_lim;
   logic          trig_hit;
   logic          rd_vld;

   // Zero or oversize requests fill the whole buffer.
   assign arm_lim  = (bus.post_count == '0 || bus.post_count > CNT_DEPTH) ? CNT_DEPTH : bus.post_count;
   assign trig_hit = !bus.trig_en || (bus.pc_in == bus.trig_pc);
   assign rd_vld   = (state_q == S_DONE) && (rd_ptr_q < cap_q);

   always_comb begin
      state_d  = state_q;
      lim_d    = lim_q;
      cap_d    = cap_q;
      rd_ptr_d = rd_ptr_q;
      wr_en    = 1'b0;
      wr_addr  = cap_q[AW-1:0];

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.arm) begin
                  // Arm from DONE drops any unread samples.
                  state_d  = S_ARMED;
                  lim_d    = arm_lim;
                  cap_d    = '0;
                  rd_ptr_d = '0;
               end else if (state_q == S_DONE) begin
                  if (rd_vld && bus.rd_ready) begin
                     rd_ptr_d = rd_ptr_q + CNT_ONE;
                     if (rd_ptr_q + CNT_ONE == cap_q) state_d = S_IDLE;
                  end else if (!rd_vld) begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_ARMED: begin
               if (trig_hit) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
                  cap_d   = CNT_ONE;
                  state_d = (lim_q == CNT_ONE) ? S_DONE : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // cap_q < lim_q <= DEPTH here, so the write pointer never wraps.
               wr_en = 1'b1;
               cap_d = cap_q + CNT_ONE;
               if (cap_q + CNT_ONE == lim_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         lim_q    <= CNT_DEPTH;
         cap_q    <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         lim_q    <= lim_d;
         cap_q    <= cap_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; contents are only meaningful below cap_count.
   always_ff @(posedge CLK) begin
      if (wr_en && !RESET) mem_q[wr_addr] <= {bus.pc_in, bus.acc_in};
   end

   assign bus.rd_valid  = rd_vld;
   assign bus.rd_data   = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.rd_index  = rd_ptr_q;
   assign bus.cap_count = cap_q;
   assign bus.state_out = state_q;
   assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_minc_trace.sv
// Directed bench for minc_trace: immediate and PC-match triggers, readout stalls, abort, clamp, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: rd_ready driven from explicit patterns.
module tb_minc_trace;
   localparam int PC_W  = 8;
   localparam int ACC_W = 8;
   localparam int DEPTH = 64;

   logic CLK = 1'b0;
   logic RESET;
   logic pc_auto;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 CLK = ~CLK;

   minc_trace_if #(.PC_W(PC_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) bus ();

   minc_trace #(.PC_W(PC_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; the sampled PC counts up by one per cycle when pc_auto is set.
   task automatic step();
      @(posedge CLK);
      #1;
      if (pc_auto) begin
         bus.pc_in  = bus.pc_in + 8'd1;
         bus.acc_in = bus.pc_in ^ 8'hA5;
      end
   endtask

   function automatic logic [15:0] sample(input logic [7:0] pc);
      return {pc, pc ^ 8'hA5};
   endfunction

   // Arm with pc_in = 0 on the arm cycle.
   task automatic arm_go(input logic ten, input logic [7:0] tpc, input logic [6:0] pcount);
      bus.pc_in      = 8'd0;
      bus.acc_in     = 8'hA5;
      bus.trig_en    = ten;
      bus.trig_pc    = tpc;
      bus.post_count = pcount;
      bus.arm        = 1'b1;
      pc_auto        = 1'b1;
      step();
      bus.arm = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && bus.state_out != 2'd3; i++) step();
      chk("done_reached", {31'd0, bus.done}, 32'd1);
   endtask

   task automatic read_all(input int n, input logic [7:0] first_pc, input string tag);
      bus.rd_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk({tag, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
         chk({tag, "_idx"}, {25'd0, bus.rd_index}, k);
         chk({tag, "_dat"}, {16'd0, bus.rd_data}, {16'd0, sample(first_pc + 8'(k))});
         step();
      end
      bus.rd_ready = 1'b0;
      chk({tag, "_end_state"}, {30'd0, bus.state_out}, 32'd0);
      chk({tag, "_end_vld"}, {31'd0, bus.rd_valid}, 32'd0);
      chk({tag, "_end_cap"}, {25'd0, bus.cap_count}, n);
   endtask

   initial begin
      logic [7:0] pat [6];
      int         exp_idx;

      pc_auto        = 1'b0;
      RESET          = 1'b1;
      bus.pc_in      = 8'd0;
      bus.acc_in     = 8'd0;
      bus.arm        = 1'b0;
      bus.abort      = 1'b0;
      bus.trig_en    = 1'b0;
      bus.trig_pc    = 8'd0;
      bus.post_count = 7'd0;
      bus.rd_ready   = 1'b0;
      repeat (3) step();
      RESET = 1'b0;
      step();
      chk("rst_state", {30'd0, bus.state_out}, 32'd0);
      chk("rst_cap", {25'd0, bus.cap_count}, 32'd0);
      chk("rst_vld", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_idx", {25'd0, bus.rd_index}, 32'd0);

      // Immediate trigger, four samples: pc 1..4.
      arm_go(1'b0, 8'd0, 7'd4);
      chk("t1_armed", {30'd0, bus.state_out}, 32'd1);
      step();
      chk("t1_capture", {30'd0, bus.state_out}, 32'd2);
      chk("t1_cap1", {25'd0, bus.cap_count}, 32'd1);
      chk("t1_vld_cap", {31'd0, bus.rd_valid}, 32'd0);
      wait_done(10);
      chk("t1_cap4", {25'd0, bus.cap_count}, 32'd4);
      read_all(4, 8'd1, "t1");

      // PC-match trigger at 0x10, full-depth capture, no wrap.
      arm_go(1'b1, 8'h10, 7'd0);
      repeat (5) step();
      chk("t2_armed_wait", {30'd0, bus.state_out}, 32'd1);
      chk("t2_no_store", {25'd0, bus.cap_count}, 32'd0);
      wait_done(200);
      chk("t2_cap64", {25'd0, bus.cap_count}, 32'd64);
      read_all(64, 8'h10, "t2");

      // Readout stalls: rd_ready 1,0,0,1 then 1,1.
      arm_go(1'b0, 8'd0, 7'd4);
      wait_done(10);
      pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
      exp_idx = 0;
      for (int i = 0; i < 6; i++) begin
         chk("t3_idx", {25'd0, bus.rd_index}, exp_idx);
         chk("t3_dat", {16'd0, bus.rd_data}, {16'd0, sample(8'(exp_idx + 1))});
         bus.rd_ready = pat[i][0];
         step();
         if (pat[i][0]) exp_idx++;
      end
      bus.rd_ready = 1'b0;
      chk("t3_end_state", {30'd0, bus.state_out}, 32'd0);
      chk("t3_end_idx", {25'd0, bus.rd_index}, 32'd4);

      // Abort after three samples captured.
      arm_go(1'b0, 8'd0, 7'd8);
      repeat (3) step();
      chk("t4_cap3_pre", {25'd0, bus.cap_count}, 32'd3);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("t4_state", {30'd0, bus.state_out}, 32'd0);
      chk("t4_cap3", {25'd0, bus.cap_count}, 32'd3);
      chk("t4_vld", {31'd0, bus.rd_valid}, 32'd0);

      // Arm and abort together in IDLE stays IDLE.
      bus.arm   = 1'b1;
      bus.abort = 1'b1;
      step();
      bus.arm   = 1'b0;
      bus.abort = 1'b0;
      chk("t4_arm_abort", {30'd0, bus.state_out}, 32'd0);

      // Oversize request clamps to DEPTH; arm in DONE re-arms.
      arm_go(1'b0, 8'd0, 7'd100);
      wait_done(100);
      chk("t5_clamp", {25'd0, bus.cap_count}, 32'd64);
      bus.arm = 1'b1;
      bus.post_count = 7'd1;
      step();
      bus.arm = 1'b0;
      chk("t5_rearm_state", {30'd0, bus.state_out}, 32'd1);
      chk("t5_rearm_cap", {25'd0, bus.cap_count}, 32'd0);
      chk("t5_rearm_vld", {31'd0, bus.rd_valid}, 32'd0);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;

      // Single sample goes ARMED -> DONE directly.
      arm_go(1'b0, 8'd0, 7'd1);
      step();
      chk("t6_done", {30'd0, bus.state_out}, 32'd3);
      chk("t6_cap1", {25'd0, bus.cap_count}, 32'd1);
      read_all(1, 8'd1, "t6");

      // Reset in DONE with two unread entries.
      arm_go(1'b0, 8'd0, 7'd4);
      wait_done(10);
      bus.rd_ready = 1'b1;
      repeat (2) step();
      bus.rd_ready = 1'b0;
      chk("t7_pre_idx", {25'd0, bus.rd_index}, 32'd2);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      chk("t7_state", {30'd0, bus.state_out}, 32'd0);
      chk("t7_vld", {31'd0, bus.rd_valid}, 32'd0);
      chk("t7_cap", {25'd0, bus.cap_count}, 32'd0);
      chk("t7_idx", {25'd0, bus.rd_index}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/minc_trace.md
MINC_TRACE -- requirements
Module: minc_trace

Interface
REQ-001 SHALL provide parameter PC_W, default 8, width of sampled program counter.
REQ-002 SHALL provide parameter ACC_W, default 8, width of sampled accumulator.
REQ-003 SHALL provide parameter DEPTH, default 64, capture buffer entries; power of two, >=2; AW = log2(DEPTH).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
  CLK  in  1  clock, all state updates on rising edge
  RESET  in  1  synchronous active-high reset
  pc_in  in  PC_W  CPU program counter sample
  acc_in  in  ACC_W  CPU accumulator sample
  arm  in  1  start pulse, enter ARMED
  abort  in  1  return to IDLE from any state
  trig_en  in  1  1 = trigger on PC match, 0 = trigger immediately
  trig_pc  in  PC_W  trigger PC value
  post_count  in  AW+1  samples to capture, latched on arm
  rd_ready  in  1  consumer accepts rd_data
  rd_valid  out  1  rd_data holds an unread sample
  rd_data  out  PC_W+ACC_W  {pc, acc} of sample at rd_index
  rd_index  out  AW+1  index of current readout sample, 0 = trigger sample
  cap_count  out  AW+1  samples captured so far
  state_out  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
  done  out  1  high while state_out = DONE

Function
REQ-006 FSM SHALL have states IDLE, ARMED, CAPTURE and DONE only; state_out SHALL be registered.
REQ-007 IDLE: arm=1 -> ARMED next cycle; SHALL latch limit N from post_count and clear cap_count, write pointer and read pointer.
REQ-008 Limit rule: post_count=0 or post_count>DEPTH SHALL give N=DEPTH; otherwise N=post_count.
REQ-009 ARMED: trigger condition SHALL be (trig_en=0) or (pc_in==trig_pc), evaluated every cycle; no sample SHALL be stored before the trigger.
REQ-010 Trigger cycle SHALL store {pc_in, acc_in} at entry 0 and set cap_count=1; next state SHALL be DONE if N=1, else CAPTURE.
REQ-011 CAPTURE: one sample SHALL be stored per cycle at entry cap_count, then cap_count increments; the store that makes cap_count=N SHALL move to DONE next cycle.
REQ-012 Capture SHALL be gapless: N consecutive cycles from the trigger cycle inclusive; the write pointer SHALL never wrap.
REQ-013 DONE: rd_valid SHALL be 1 while read pointer < cap_count; rd_data SHALL equal the stored entry at rd_index, combinational from storage.
REQ-014 Transfer SHALL occur when rd_valid & rd_ready on a rising edge; rd_index SHALL then increment by 1.
REQ-015 rd_data and rd_index SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-016 After the transfer of entry N-1, rd_valid SHALL be 0 and the FSM SHALL go to IDLE on the next cycle; cap_count SHALL hold its value until the next arm.
REQ-017 rd_valid SHALL be 0 in IDLE, ARMED and CAPTURE.
REQ-018 arm SHALL be ignored in ARMED and CAPTURE; arm in DONE SHALL discard unread data and re-arm as from IDLE.
REQ-019 abort=1 SHALL force IDLE next cycle from any state with priority over arm, trigger and transfer; cap_count SHALL hold its value; storage contents are don't-care.
REQ-020 Simultaneous arm and abort in IDLE SHALL result in IDLE.

Reset
REQ-021 RESET=1 at a rising edge SHALL set state IDLE, cap_count=0, rd_index=0, rd_valid=0, done=0, with priority over abort and arm.
REQ-022 Reset during CAPTURE or DONE SHALL abandon the capture; buffer contents SHALL not be required to be cleared.
REQ-023 rd_data SHALL be don't-care while rd_valid=0.

Verification
REQ-024 Bench SHALL cover: trig_en=0, post_count=4, pc_in counting 0,1,2,... from the arm cycle -> entries pc 1,2,3,4 read back in order, done=1, then IDLE.
REQ-025 Bench SHALL cover: trig_en=1, trig_pc=8'h10, post_count=0 -> 64 samples captured starting at pc=8'h10, cap_count=64, no wrap.
REQ-026 Bench SHALL cover: rd_ready toggled 1,0,0,1 in DONE -> rd_data/rd_index held during stalls, no entry lost or duplicated.
REQ-027 Bench SHALL cover: abort asserted mid-CAPTURE after 3 samples -> IDLE next cycle, cap_count=3, rd_valid=0.
REQ-028 Bench SHALL cover: post_count=100 with DEPTH=64 -> clamped, cap_count=64; post_count=1 -> ARMED to DONE directly.
REQ-029 Bench SHALL cover: RESET pulsed during DONE with 2 unread entries -> state_out=0, rd_valid=0, cap_count=0.
